// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and alignment constants for the fetch stage
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int ALIGN_BITS = $clog2(INSTR_BYTES);
  localparam logic [ALIGN_BITS-1:0] ALIGN_MASK = '1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: IMEM request/response port and decode-side valid/ready handshake
interface fetch_if #(parameter int XLEN = 32, parameter int ILEN = 32);
  logic imem_req_valid;
  logic imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic if_valid;
  logic if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    input imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
  modport slave (
    input imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: one-entry valid/ready holding register for fetched instruction and its pc
module fetch_out_reg #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fill,
  input  logic            flush,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);
  logic valid_q, valid_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  // flush beats fill, fill beats drain; payload only moves on fill
  always_comb begin
    valid_d = flush ? 1'b0 : fill ? 1'b1 : out_ready ? 1'b0 : valid_q;
    instr_d = fill ? in_instr : instr_q;
    pc_d = fill ? in_pc : pc_q;
  end
  // holding register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
    end
  end
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc = pc_q;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: IF-stage sequencer for program_counter and a single-outstanding IMEM port
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic [XLEN-1:0] pc_cur,
  output logic            pc_step,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            misalign,
  fetch_if.master         bus
);
  state_e state_q, state_d;
  logic kill_q, kill_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic redir, accept, rsp, fill;
  // request gating, redirect priority, kill tracking and next state
  always_comb begin
    redir = redirect_valid && state_q != IDLE;
    bus.imem_req_valid = state_q == REQ && !halt && !redirect_valid && (!bus.if_valid || bus.if_ready);
    bus.imem_addr = pc_cur;
    accept = bus.imem_req_valid && bus.imem_req_ready;
    rsp = state_q == WAIT_RSP && bus.imem_rsp_valid;
    fill = rsp && !kill_q && !redirect_valid;
    pc_step = accept;
    pc_load = redir;
    pc_target = {redirect_target[XLEN-1:ALIGN_BITS], ALIGN_BITS'(0)};
    misalign = redir && |(redirect_target[ALIGN_BITS-1:0] & ALIGN_MASK);
    req_pc_d = accept ? pc_cur : req_pc_q;
    kill_d = rsp ? 1'b0 : (state_q == WAIT_RSP && redirect_valid) ? 1'b1 : kill_q;
    state_d = state_q == IDLE ? REQ : accept ? WAIT_RSP : rsp ? REQ : state_q;
  end
  // fsm, kill flag and address of the outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kill_q <= 1'b0;
      req_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      kill_q <= kill_d;
      req_pc_q <= req_pc_d;
    end
  end
  fetch_out_reg #(.XLEN(XLEN), .ILEN(ILEN)) u_out (
    .clk       (clk),
    .rst       (rst),
    .fill      (fill),
    .flush     (redir),
    .in_instr  (bus.imem_rsp_data),
    .in_pc     (req_pc_q),
    .out_ready (bus.if_ready),
    .out_valid (bus.if_valid),
    .out_instr (bus.if_instr),
    .out_pc    (bus.if_pc)
  );
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios against a pc model and a fixed-latency IMEM model
module tb_fetch_controller;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic rst, halt, redirect_valid, pc_step, pc_load, misalign, pend;
  logic [31:0] pc_cur, pc_target, redirect_target, paddr, a;
  int total = 0, bad = 0, lat = 1, cnt, steps = 0, accepts = 0, both = 0;

  fetch_if #(.XLEN(32), .ILEN(32)) bus();

  fetch_controller #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .halt            (halt),
    .pc_cur          (pc_cur),
    .pc_step         (pc_step),
    .pc_load         (pc_load),
    .pc_target       (pc_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .misalign        (misalign),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) pc_cur <= 32'h0;
    else if (pc_load) pc_cur <= pc_target;
    else if (pc_step) pc_cur <= pc_cur + 32'd4;

  always @(posedge clk or posedge rst)
    if (rst) begin
      pend <= 1'b0;
      cnt <= 0;
      paddr <= 32'h0;
    end else if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend <= 1'b1;
      cnt <= lat - 1;
      paddr <= bus.imem_addr;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end

  assign bus.imem_rsp_valid = pend && cnt == 0;
  assign bus.imem_rsp_data = paddr ^ K;

  always @(negedge clk) begin
    if (pc_step) steps++;
    if (bus.imem_req_valid && bus.imem_req_ready) accepts++;
    if (pc_step && pc_load) both++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b exp=0", bus.if_valid); end
    total++; if (bus.if_instr !== 32'h0) begin bad++; $display("FAIL reset_if_instr got=%h exp=0", bus.if_instr); end
    total++; if (bus.if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc got=%h exp=0", bus.if_pc); end
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
    total++; if (pc_step !== 1'b0 || pc_load !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", pc_step, pc_load); end
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h103;
    #1;
    total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL idle_redirect_load got=%b exp=0", pc_load); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL idle_redirect_misalign got=%b exp=0", misalign); end
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_req_valid got=%b exp=0", bus.imem_req_valid); end
    redirect_valid = 1'b0;
    tick;
  endtask

  task automatic test_stream;
    int s0;
    s0 = steps;
    for (int i = 0; i < 3; i++) begin
      a = 32'(4 * i);
      total++; if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL stream_req_valid got=%b exp=1", bus.imem_req_valid); end
      total++; if (bus.imem_addr !== a) begin bad++; $display("FAIL stream_addr got=%h exp=%h", bus.imem_addr, a); end
      total++; if (pc_step !== 1'b1) begin bad++; $display("FAIL stream_step got=%b exp=1", pc_step); end
      tick;
      total++; if (bus.imem_req_valid !== 1'b0 || pc_step !== 1'b0) begin bad++; $display("FAIL stream_wait got=%b%b exp=00", bus.imem_req_valid, pc_step); end
      tick;
      total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL stream_if_valid got=%b exp=1", bus.if_valid); end
      total++; if (bus.if_pc !== a) begin bad++; $display("FAIL stream_if_pc got=%h exp=%h", bus.if_pc, a); end
      total++; if (bus.if_instr !== (a ^ K)) begin bad++; $display("FAIL stream_if_instr got=%h exp=%h", bus.if_instr, a ^ K); end
    end
    total++; if (steps - s0 !== 3) begin bad++; $display("FAIL stream_step_count got=%0d exp=3", steps - s0); end
  endtask

  task automatic test_stall;
    bus.if_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid got=%b exp=0", bus.imem_req_valid); end
      total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8) begin bad++; $display("FAIL stall_hold_pc got=%b/%h exp=1/00000008", bus.if_valid, bus.if_pc); end
      total++; if (bus.if_instr !== (32'h8 ^ K)) begin bad++; $display("FAIL stall_hold_instr got=%h exp=%h", bus.if_instr, 32'h8 ^ K); end
      tick;
    end
    bus.if_ready = 1'b1;
    #1;
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'hC) begin bad++; $display("FAIL stall_resume got=%b/%h exp=1/0000000c", bus.imem_req_valid, bus.imem_addr); end
    tick;
    tick;
    total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hC) begin bad++; $display("FAIL stall_next got=%b/%h exp=1/0000000c", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_redirect_wait;
    lat = 3;
    total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("FAIL rw_addr got=%h exp=00000010", bus.imem_addr); end
    tick;
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    #1;
    total++; if (pc_load !== 1'b1 || pc_step !== 1'b0) begin bad++; $display("FAIL rw_pulses got=%b%b exp=10", pc_load, pc_step); end
    total++; if (pc_target !== 32'h100 || misalign !== 1'b0) begin bad++; $display("FAIL rw_target got=%h/%b exp=00000100/0", pc_target, misalign); end
    tick;
    redirect_valid = 1'b0;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_wait2 got=%b exp=0", bus.imem_req_valid); end
    tick;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_wait3 got=%b exp=0", bus.imem_req_valid); end
    tick;
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rw_stale_valid got=%b exp=0", bus.if_valid); end
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++; $display("FAIL rw_refetch got=%b/%h exp=1/00000100", bus.imem_req_valid, bus.imem_addr); end
    lat = 1;
  endtask

  task automatic test_redirect_rsp;
    tick;
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    #1;
    total++; if (pc_load !== 1'b1 || pc_step !== 1'b0) begin bad++; $display("FAIL rr_pulses got=%b%b exp=10", pc_load, pc_step); end
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rr_req_valid got=%b exp=0", bus.imem_req_valid); end
    tick;
    redirect_valid = 1'b0;
    #1;
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rr_dropped got=%b exp=0", bus.if_valid); end
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h200) begin bad++; $display("FAIL rr_refetch got=%b/%h exp=1/00000200", bus.imem_req_valid, bus.imem_addr); end
    tick;
    tick;
    total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200) begin bad++; $display("FAIL rr_deliver got=%b/%h exp=1/00000200", bus.if_valid, bus.if_pc); end
    total++; if (bus.if_instr !== (32'h200 ^ K)) begin bad++; $display("FAIL rr_instr got=%h exp=%h", bus.if_instr, 32'h200 ^ K); end
  endtask

  task automatic test_misalign;
    bus.if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h103;
    #1;
    total++; if (misalign !== 1'b1 || pc_load !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b%b exp=11", misalign, pc_load); end
    total++; if (pc_target !== 32'h100) begin bad++; $display("FAIL mis_target got=%h exp=00000100", pc_target); end
    tick;
    redirect_valid = 1'b0;
    #1;
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL mis_flush got=%b exp=0", bus.if_valid); end
    total++; if (misalign !== 1'b0 || pc_load !== 1'b0) begin bad++; $display("FAIL mis_one_cycle got=%b%b exp=00", misalign, pc_load); end
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++; $display("FAIL mis_refetch got=%b/%h exp=1/00000100", bus.imem_req_valid, bus.imem_addr); end
    bus.if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0 || pc_step !== 1'b0) begin bad++; $display("FAIL req_redirect_block got=%b%b exp=00", bus.imem_req_valid, pc_step); end
    tick;
    redirect_valid = 1'b0;
    #1;
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h300) begin bad++; $display("FAIL req_redirect_resume got=%b/%h exp=1/00000300", bus.imem_req_valid, bus.imem_addr); end
  endtask

  task automatic test_halt_reset;
    tick;
    halt = 1'b1;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL halt_wait got=%b exp=0", bus.imem_req_valid); end
    tick;
    total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h300) begin bad++; $display("FAIL halt_deliver got=%b/%h exp=1/00000300", bus.if_valid, bus.if_pc); end
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL halt_block1 got=%b exp=0", bus.imem_req_valid); end
    tick;
    total++; if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0) begin bad++; $display("FAIL halt_block2 got=%b/%b exp=0/0", bus.imem_req_valid, bus.if_valid); end
    tick;
    total++; if (bus.imem_req_valid !== 1'b0 || pc_step !== 1'b0) begin bad++; $display("FAIL halt_block3 got=%b%b exp=00", bus.imem_req_valid, pc_step); end
    halt = 1'b0;
    lat = 3;
    #1;
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h304) begin bad++; $display("FAIL halt_release got=%b/%h exp=1/00000304", bus.imem_req_valid, bus.imem_addr); end
    tick;
    total++; if (bus.if_pc !== 32'h300 || bus.if_instr !== (32'h300 ^ K)) begin bad++; $display("FAIL pre_reset_hold got=%h/%h exp=00000300/%h", bus.if_pc, bus.if_instr, 32'h300 ^ K); end
    rst = 1'b1;
    #1;
    total++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin bad++; $display("FAIL async_reset_data got=%h/%h exp=0/0", bus.if_pc, bus.if_instr); end
    total++; if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%b/%b exp=0/0", bus.if_valid, bus.imem_req_valid); end
    total++; if (pc_step !== 1'b0 || pc_load !== 1'b0 || misalign !== 1'b0) begin bad++; $display("FAIL async_reset_pulses got=%b%b%b exp=000", pc_step, pc_load, misalign); end
    lat = 1;
    tick;
    rst = 1'b0;
    tick;
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL post_reset_fetch got=%b/%h exp=1/00000000", bus.imem_req_valid, bus.imem_addr); end
    tick;
    total++; if (both !== 0) begin bad++; $display("FAIL step_load_exclusive got=%0d exp=0", both); end
    total++; if (steps !== accepts) begin bad++; $display("FAIL step_per_accept got=%0d exp=%0d", steps, accepts); end
  endtask

  initial begin
    rst = 1'b1;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    test_reset;
    test_stream;
    test_stall;
    test_redirect_wait;
    test_redirect_rsp;
    test_misalign;
    test_halt_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
